linear_layer_start_fifo_srl_rd: RTL

Read-side FIFO controller for the start-token channels of the Linear_Layer_i4xi4_q dataflow region. It owns the shift-register storage, the occupancy counter, a first-word-fall-through output register and the full/empty handshake. A producer's start or done pulse enters through the write port and is delivered to a consumer PE (e.g. PE_i4xi4_pack_2x2) through the read port. It is the consuming end of the existing write-only SRL primitive, with the same storage semantics.

---
 rtl/linear_layer_start_fifo_srl_rd.sv | 97 +++++++++
 1 files changed

// File: rtl/linear_layer_start_fifo_srl_rd.sv
// Read-side start-token FIFO: shift-register storage, occupancy counter and a
// first-word-fall-through output register. Optional sticky error flag: SRL_FIFO_ERR_FLAG_EN.
module linear_layer_start_fifo_srl_rd #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
`ifdef SRL_FIFO_ERR_FLAG_EN
  ,
  output logic                  if_err
`endif
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_dout_vld;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_take;
  logic                  w_load;
  logic                  w_cnt_nz;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_push    = if_write & if_write_ce & if_full_n;
  assign w_pop     = if_read & if_read_ce & if_empty_n;
  assign w_cnt_nz  = (r_cnt != '0);
  // The output register wants a new head when it is empty or being popped.
  assign w_take    = ~r_dout_vld | w_pop;
  assign w_load    = w_take & w_cnt_nz;
  assign w_rd_addr = ADDR_WIDTH'(r_cnt - 1'b1);

  // NOTE: storage has no reset on purpose; r_cnt alone decides which entries
  // are meaningful, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_mem[i] <= r_mem[i-1];
      end
      r_mem[0] <= if_din;
    end
  end

  // NOTE: state uses non-blocking assignments so the load reads the pre-shift
  // array; a simultaneous push and load therefore keeps FIFO order intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
    end else begin
      if (w_load) begin
        r_dout     <= r_mem[w_rd_addr];
        r_dout_vld <= 1'b1;
      end else if (w_take) begin
        r_dout_vld <= 1'b0;
      end

      case ({w_push, w_load})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign if_full_n  = (r_cnt != (ADDR_WIDTH+1)'(DEPTH));
  assign if_empty_n = r_dout_vld;
  assign if_dout    = r_dout;

`ifdef SRL_FIFO_ERR_FLAG_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((if_write & if_write_ce & ~if_full_n) |
                 (if_read  & if_read_ce  & ~if_empty_n)) begin
      r_err <= 1'b1;
    end
  end

  assign if_err = r_err;
`endif

endmodule
